// File: rtl/button_event_arbiter_pkg.sv
// Shared types and defaults for the button event arbiter.
// Long-press support is enabled by BUTTON_EVT_LONG_PRESS_EN.
package button_evt_pkg;

    localparam int NUM_BTNS_DEF    = 4;
    localparam int IDX_W_DEF       = 2;
    localparam int HOLD_CLOCKS_DEF = 1024;
    localparam int HOLD_CLOG2_DEF  = 10;

    // Button 0 gets first priority after reset.
    localparam int LAST_RESET = NUM_BTNS_DEF - 1;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] idx;
        logic                 long_press;
    } evt_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/button_event_arbiter_if.sv
// Valid/ready event channel from the arbiter to its consumer.
// Carries the granted button index and the long-press flag.
interface button_event_arbiter_if #(
    parameter int IDX_W = 2
);
    logic             evt_valid;
    logic             evt_ready;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_long;

    modport master (
        output evt_valid,
        output evt_idx,
        output evt_long,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_idx,
        input  evt_long,
        output evt_ready
    );
endinterface

// File: rtl/button_event_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request after last, wrapping.
module rr_arbiter #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] grant_idx,
    output logic         grant_any
);
    int j;

    // Walk from farthest to nearest so the nearest request wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        j         = 0;
        for (int k = N; k >= 1; k--) begin
            j = (int'(last) + k) % N;
            if (req[j]) begin
                grant_idx = W'(j);
                grant_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/button_event_arbiter.sv
// Button press edge detect, pending tracking and round-robin serialiser.
// Define BUTTON_EVT_LONG_PRESS_EN to add per-button long-press events.
module button_event_arbiter
    import button_evt_pkg::*;
#(
    parameter int NUM_BTNS    = NUM_BTNS_DEF,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int HOLD_CLOCKS = HOLD_CLOCKS_DEF,
    parameter int HOLD_CLOG2  = HOLD_CLOG2_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_db,
    button_event_arbiter_if.master evt,
    output logic [NUM_BTNS-1:0] pending,
    output logic                overflow
);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_BTNS - 1);

    state_t              state, state_n;
    logic [NUM_BTNS-1:0] prev;
    logic [NUM_BTNS-1:0] rise;
    logic [NUM_BTNS-1:0] req;
    logic [NUM_BTNS-1:0] gmask;
    logic [NUM_BTNS-1:0] clr_s;
    logic [NUM_BTNS-1:0] pending_n;
    logic [IDX_W-1:0]    last;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_any;
    logic                load;
    logic                ovf_n;

    assign rise = btn_db & ~prev;

    rr_arbiter #(
        .N (NUM_BTNS),
        .W (IDX_W)
    ) u_rr (
        .req       (req),
        .last      (last),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (grant_any) begin
                    load    = 1'b1;
                    state_n = PRESENT;
                end
            end
            PRESENT: begin
                if (evt.evt_ready) begin
                    load    = grant_any;
                    state_n = grant_any ? PRESENT : IDLE;
                end
            end
        endcase
    end

    assign gmask = load ? (NUM_BTNS'(1) << grant_idx) : '0;

`ifdef BUTTON_EVT_LONG_PRESS_EN
    localparam logic [HOLD_CLOG2-1:0] HOLD_MAX = HOLD_CLOG2'(HOLD_CLOCKS - 1);

    logic [HOLD_CLOG2-1:0] cnt [NUM_BTNS];
    logic [NUM_BTNS-1:0]   long_pend;
    logic [NUM_BTNS-1:0]   long_set;
    logic [NUM_BTNS-1:0]   clr_l;
    logic                  serve_long;
    logic                  long_q;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_hold
        always_ff @(posedge clk or posedge rst) begin
            if (rst)               cnt[i] <= '0;
            else if (!btn_db[i])   cnt[i] <= '0;
            else if (cnt[i] != HOLD_MAX) cnt[i] <= cnt[i] + 1'b1;
        end
        // Fires only on the step into saturation: once per hold.
        assign long_set[i] = btn_db[i] && (cnt[i] == HOLD_MAX - 1'b1);
    end

    assign req        = pending | long_pend;
    assign serve_long = ~pending[grant_idx];
    assign clr_s      = serve_long ? '0 : gmask;
    assign clr_l      = serve_long ? gmask : '0;
    assign pending_n  = (pending & ~clr_s) | rise;
    assign ovf_n      = |(rise & pending & ~clr_s)
                      | |(long_set & long_pend & ~clr_l);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            long_pend <= '0;
            long_q    <= 1'b0;
        end else begin
            long_pend <= (long_pend & ~clr_l) | long_set;
            if (load) long_q <= serve_long;
        end
    end

    assign evt.evt_long = long_q;
`else
    assign req          = pending;
    assign clr_s        = gmask;
    assign pending_n    = (pending & ~clr_s) | rise;
    assign ovf_n        = |(rise & pending & ~clr_s);
    assign evt.evt_long = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev     <= '1;
            pending  <= '0;
            overflow <= 1'b0;
            idx_q    <= '0;
            last     <= LAST_RST;
        end else begin
            prev     <= btn_db;
            pending  <= pending_n;
            overflow <= ovf_n;
            if (load) begin
                idx_q <= grant_idx;
                last  <= grant_idx;
            end
        end
    end

    assign evt.evt_valid = (state == PRESENT);
    assign evt.evt_idx   = idx_q;
endmodule

// File: tb/tb_button_event_arbiter.sv
// Scenario tests for button_event_arbiter with a scoreboard of expected events.
// Long-press scenario follows BUTTON_EVT_LONG_PRESS_EN.
module tb_button_event_arbiter;
    import button_evt_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_db = 4'b0000;
    logic [3:0] pending;
    logic       overflow;

    int n_cmp = 0;
    int n_bad = 0;
    evt_t exp_q[$];
    evt_t e;

    button_event_arbiter_if #(.IDX_W(2)) bus ();

    button_event_arbiter #(
        .NUM_BTNS    (4),
        .IDX_W       (2),
        .HOLD_CLOCKS (16),
        .HOLD_CLOG2  (10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_db   (btn_db),
        .evt      (bus),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic do_reset(input logic [3:0] b);
        @(negedge clk);
        rst = 1'b1;
        btn_db = b;
        bus.evt_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic push(input int idx, input logic lp);
        e.idx = 2'(idx);
        e.long_press = lp;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        do_reset(4'b0010);
        n_cmp++;
        if ({bus.evt_valid, bus.evt_idx, bus.evt_long, pending, overflow} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset_vals got v=%b i=%0d l=%b p=%b o=%b want all 0",
                     bus.evt_valid, bus.evt_idx, bus.evt_long, pending, overflow);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.evt_valid, pending} !== 5'b0) begin
                n_bad++;
                $display("FAIL held_thru_reset got v=%b p=%b want 0", bus.evt_valid, pending);
            end
        end
        btn_db = 4'b0000;
        @(negedge clk);
        btn_db = 4'b0010;
        push(1, 1'b0);
        @(negedge clk);
        n_cmp++;
        if ({bus.evt_valid, pending} !== 5'b0_0010) begin
            n_bad++;
            $display("FAIL pend_edge_k got v=%b p=%b want 0 0010", bus.evt_valid, pending);
        end
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if ({bus.evt_valid, bus.evt_idx, bus.evt_long} !== {1'b1, e.idx, e.long_press}) begin
            n_bad++;
            $display("FAIL evt_k1 got v=%b i=%0d l=%b want 1 %0d %b",
                     bus.evt_valid, bus.evt_idx, bus.evt_long, e.idx, e.long_press);
        end
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
        n_cmp++;
        if (bus.evt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_after_acc got %b want 0", bus.evt_valid);
        end
        btn_db = 4'b0000;
    endtask

    task automatic test_back_to_back;
        int w;
        do_reset(4'b0000);
        bus.evt_ready = 1'b1;
        @(negedge clk);
        btn_db = 4'b1111;
        for (int i = 0; i < 4; i++) push(i, 1'b0);
        w = 0;
        while (bus.evt_valid !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.evt_valid, bus.evt_idx} !== {1'b1, e.idx}) begin
                n_bad++;
                $display("FAIL b2b_%0d got v=%b i=%0d want 1 %0d",
                         i, bus.evt_valid, bus.evt_idx, e.idx);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({bus.evt_valid, pending} !== 5'b0) begin
            n_bad++;
            $display("FAIL b2b_end got v=%b p=%b want 0", bus.evt_valid, pending);
        end
        bus.evt_ready = 1'b0;
        btn_db = 4'b0000;
    endtask

    task automatic test_stall;
        int bad;
        do_reset(4'b0000);
        @(negedge clk);
        btn_db = 4'b0100;
        push(2, 1'b0);
        push(2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if ({bus.evt_valid, bus.evt_idx} !== 3'b1_10) bad++;
            if (c == 4) begin
                n_cmp++;
                if ({pending[2], overflow} !== 2'b10) begin
                    n_bad++;
                    $display("FAIL second_press got p2=%b o=%b want 1 0", pending[2], overflow);
                end
            end
            if (c == 7 || c == 8) begin
                n_cmp++;
                if (overflow !== (c == 7)) begin
                    n_bad++;
                    $display("FAIL ovf_c%0d got %b want %b", c, overflow, c == 7);
                end
            end
            if (c == 2 || c == 5) btn_db = 4'b0000;
            if (c == 3 || c == 6) btn_db = 4'b0100;
            @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL stall_stable got %0d unstable cycles want 0", bad);
        end
        bus.evt_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.evt_valid, bus.evt_idx} !== {1'b1, e.idx}) begin
                n_bad++;
                $display("FAIL stall_drain_%0d got v=%b i=%0d want 1 %0d",
                         i, bus.evt_valid, bus.evt_idx, e.idx);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({bus.evt_valid, pending} !== 5'b0) begin
            n_bad++;
            $display("FAIL stall_end got v=%b p=%b want 0", bus.evt_valid, pending);
        end
        bus.evt_ready = 1'b0;
        btn_db = 4'b0000;
    endtask

    task automatic test_round_robin;
        do_reset(4'b0000);
        bus.evt_ready = 1'b1;
        @(negedge clk);
        btn_db = 4'b1001;
        push(0, 1'b0);
        push(3, 1'b0);
        @(negedge clk);
        btn_db = 4'b0000;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.evt_valid, bus.evt_idx} !== {1'b1, e.idx}) begin
                n_bad++;
                $display("FAIL rr_a%0d got v=%b i=%0d want 1 %0d",
                         i, bus.evt_valid, bus.evt_idx, e.idx);
            end
            @(negedge clk);
        end
        btn_db = 4'b0010;
        @(negedge clk);
        btn_db = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        btn_db = 4'b1001;
        push(3, 1'b0);
        push(0, 1'b0);
        @(negedge clk);
        btn_db = 4'b0000;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({bus.evt_valid, bus.evt_idx} !== {1'b1, e.idx}) begin
                n_bad++;
                $display("FAIL rr_b%0d got v=%b i=%0d want 1 %0d",
                         i, bus.evt_valid, bus.evt_idx, e.idx);
            end
            @(negedge clk);
        end
        bus.evt_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        int seen;
        do_reset(4'b0000);
        @(negedge clk);
        btn_db = 4'b0110;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if ({bus.evt_valid, bus.evt_idx, pending} !== 7'b1_01_0100) begin
            n_bad++;
            $display("FAIL pre_rst got v=%b i=%0d p=%b want 1 1 0100",
                     bus.evt_valid, bus.evt_idx, pending);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bus.evt_valid, bus.evt_idx, bus.evt_long, pending, overflow} !== 9'b0) begin
            n_bad++;
            $display("FAIL async_rst got v=%b i=%0d p=%b want 0",
                     bus.evt_valid, bus.evt_idx, pending);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.evt_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.evt_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_bad++;
            $display("FAIL post_rst_evt got %0d events want 0", seen);
        end
        bus.evt_ready = 1'b0;
        btn_db = 4'b0000;
    endtask

    task automatic test_long_press;
        int extra;
        do_reset(4'b0000);
        bus.evt_ready = 1'b1;
        @(negedge clk);
        btn_db = 4'b0010;
        push(1, 1'b0);
`ifdef BUTTON_EVT_LONG_PRESS_EN
        push(1, 1'b1);
`endif
        extra = 0;
        for (int c = 0; c < 46; c++) begin
            @(negedge clk);
            if (c == 39) btn_db = 4'b0000;
            if (bus.evt_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if ({bus.evt_idx, bus.evt_long} !== {e.idx, e.long_press}) begin
                        n_bad++;
                        $display("FAIL long_evt got i=%0d l=%b want %0d %b",
                                 bus.evt_idx, bus.evt_long, e.idx, e.long_press);
                    end
                end
            end
        end
        n_cmp++;
        if (extra != 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL long_count got extra=%0d missing=%0d want 0 0",
                     extra, exp_q.size());
        end
        bus.evt_ready = 1'b0;
    endtask

    initial begin
        bus.evt_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_round_robin();
        test_reset_mid();
        test_long_press();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/button_event_arbiter.md
# button_event_arbiter

Collects debounced button levels from `debouncer` instances, turns each rising edge into a one-shot press event, and serialises the events to a single consumer over a valid/ready handshake. Arbitration between simultaneous presses is round-robin, so no button starves. It sits between the per-button `debouncer` instances and the UI/control FSM that consumes button events.

## Interface
Parameters:
- `NUM_BTNS`, default 4: number of debounced button inputs (2..16).
- `IDX_W`, default 2: width of the event index; must be at least clog2(`NUM_BTNS`).
- `HOLD_CLOCKS`, default 1024: long-press threshold in clocks. Used only with `LONG_PRESS_EN`.
- `HOLD_CLOG2`, default 10: counter width for `HOLD_CLOCKS`.

Ports:
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `btn_db` in `NUM_BTNS`: debounced button levels, already synchronous to `clk`.
- `evt_valid` out 1: an event is presented.
- `evt_ready` in 1: the consumer accepts the event.
- `evt_idx` out `IDX_W`: index of the button that produced the event.
- `evt_long` out 1: the event is a long press. Tied to 0 without `LONG_PRESS_EN`.
- `pending` out `NUM_BTNS`: per-button pending-request status.
- `overflow` out 1: one-cycle pulse when a press coalesces into an already pending request.

## Operation
- Edge detect:
  - `prev` register samples `btn_db` every clock.
  - `rise[i] = btn_db[i] & ~prev[i]`.
  - `prev` resets to all ones, so a button held through reset produces no event.
- Pending set:
  - `rise[i]` sets `pending[i]`.
  - If `pending[i]` is already 1, the press is coalesced and `overflow` pulses for one cycle. This happens once per clock, even if several buttons coalesce.
- Output register states:
  - IDLE: `evt_valid`=0.
  - PRESENT: `evt_valid`=1.
- Load:
  - A load happens when in IDLE with any pending bit set, or in PRESENT with `evt_ready`=1 (accept).
  - On load, the arbiter grants the first pending index searching from `last+1` upward, wrapping modulo `NUM_BTNS`.
  - `evt_idx` takes the granted index, the granted pending bit clears, and `last` takes the granted index.
- Accept with nothing pending: return to IDLE with `evt_valid`=0.
- Stability: `evt_valid`, `evt_idx` and `evt_long` hold stable while `evt_valid`=1 and `evt_ready`=0.
- `evt_ready` while IDLE is ignored.
- Simultaneous set and clear on the same bit: set wins. A new press on the button being granted stays pending, with no `overflow`.
- Reset mid-handshake: outputs drop immediately and the in-flight event is lost.

## Timing
- Reset values:
  - `evt_valid`=0, `evt_idx`=0, `evt_long`=0, `pending`=0, `overflow`=0.
  - `last`=`NUM_BTNS`-1, so button 0 has first priority.
  - `prev`=all ones; hold counters=0.
- Latency:
  - `btn_db` rises before edge k, so `pending` sets at edge k.
  - If the output is IDLE, `evt_valid` rises at edge k+1.
- Throughput: one event per clock while `evt_ready` is held high and requests remain.
- `overflow` is registered and asserts at the same edge the coalesced press is sampled.

## Configuration
- `BUTTON_EVT_LONG_PRESS_EN` defined:
  - Each button has a saturating `HOLD_CLOG2`-bit counter that counts while `btn_db[i]`=1 and clears when it is 0.
  - When the counter reaches `HOLD_CLOCKS`-1, a separate `long_pend[i]` bit sets, once per hold.
  - The button's request is `pending[i] | long_pend[i]`. Short has priority within a button.
  - A grant serves one kind only. `evt_long`=1 when `long_pend` is served; that bit clears.
  - Coalescing on `long_pend` also pulses `overflow`.
- Not defined: no counters or `long_pend` bits are built, and `evt_long` is constant 0.

## Structure
- Package `button_evt_pkg` holds:
  - defaults for `NUM_BTNS`, `IDX_W`, `HOLD_CLOCKS`;
  - the event record type (idx, long);
  - the `LAST_RESET` constant.
- Sub-module `rr_arbiter`: combinational round-robin pick taking `req` and `last`, returning `grant_idx` and `grant_any`. It is reused later by other shared-resource blocks.

## Test plan
- Reset with `btn_db`=4'b0010 held, then release and re-press btn1 → no event before the re-press; after it, `evt_valid` at edge k+1 with `evt_idx`=1.
- `btn_db` 0→4'b1111 in one cycle, `evt_ready`=1 → events with idx 0,1,2,3 on four consecutive cycles, then `evt_valid`=0.
- `evt_ready`=0 for 10 cycles after a btn2 press → `evt_idx`=2 is stable throughout; a second btn2 press in that window sets `pending[2]` with no `overflow`; a third press pulses `overflow`=1.
- Round-robin fairness: last grant = 3, with btn0 and btn3 pending → next grant is 0, then 3.
- Assert `rst` while `evt_valid`=1 → all outputs reach their reset values asynchronously; no event after release.
- With `BUTTON_EVT_LONG_PRESS_EN`, `HOLD_CLOCKS`=16, btn1 held 40 cycles → one short event, then exactly one event with `evt_long`=1 and idx 1.
